// File: rtl/alu_pkg.sv
// Shared ALU definitions for the KGP-RISC multiply/divide datapaths.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Declared signed so a width cast sign-extends to all ones at any WIDTH.
  localparam logic signed [WIDTH_DEF-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/shift_divide_step.sv
// One restoring shift-subtract iteration on the {high,low} register pair.
module shift_divide_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] high_i,
  input  logic [WIDTH-1:0] low_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] high_o,
  output logic [WIDTH-1:0] low_o
);

  logic [WIDTH:0] w_sh_high;
  logic [WIDTH:0] w_trial;

  // The shifted remainder needs WIDTH+1 bits: it can reach 2*divisor-1.
  assign w_sh_high = {high_i, low_i[WIDTH-1]};
  assign w_trial   = w_sh_high - {1'b0, divisor_i};

  assign high_o = w_trial[WIDTH] ? w_sh_high[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign low_o  = {low_i[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/seq_shift_divide.sv
// Iterative restoring divider, one quotient bit per clock; remainder in high, quotient in low.
// Build option: SEQ_SHIFT_DIVIDE_SIGNED_EN selects two's-complement operands.
module seq_shift_divide
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] high_o,
  output logic [WIDTH-1:0] low_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: start_i is accepted on any edge where the unit is not in RUN;
  // busy_o marks RUN, done_o pulses for the first DONE cycle and the result holds afterwards.
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_low;
  logic [WIDTH-1:0] r_div;
  logic             r_dz;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_step_high;
  logic [WIDTH-1:0] w_step_low;
  logic [WIDTH-1:0] w_load_dvd;
  logic [WIDTH-1:0] w_load_dvs;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_accept   = start_i && (r_state != ST_RUN);
  assign w_last     = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH-1));
  assign w_div_zero = (divisor_i == '0);

  shift_divide_step #(.WIDTH(WIDTH)) u_step (
    .high_i    (r_high),
    .low_i     (r_low),
    .divisor_i (r_div),
    .high_o    (w_step_high),
    .low_o     (w_step_low)
  );

`ifdef SEQ_SHIFT_DIVIDE_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;

  // Magnitudes go through the unsigned core; signs are reapplied on the last iteration.
  assign w_load_dvd = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
  assign w_load_dvs = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
  assign w_q_fin    = r_q_neg ? -w_step_low  : w_step_low;
  assign w_r_fin    = r_r_neg ? -w_step_high : w_step_high;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      r_r_neg <= dividend_i[WIDTH-1];
    end
  end
`else
  assign w_load_dvd = dividend_i;
  assign w_load_dvs = divisor_i;
  assign w_q_fin    = w_step_low;
  assign w_r_fin    = w_step_high;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == ST_DONE) && ((r_state != ST_DONE) || w_accept);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start_i) w_state_next = w_div_zero ? ST_DONE : ST_RUN;
      ST_RUN:           if (w_last)  w_state_next = ST_DONE;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (r_state == ST_RUN);
    done_o      = r_done;
    dbg_state_o = r_state;
    div_zero_o  = r_dz;
    high_o      = r_high;
    low_o       = r_low;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt  <= '0;
      r_high <= '0;
      r_low  <= '0;
      r_div  <= '0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_div_zero) begin
        r_high <= dividend_i;
        r_low  <= WIDTH'(DIV_ZERO_Q);
        r_dz   <= 1'b1;
      end else begin
        r_high <= '0;
        r_low  <= w_load_dvd;
        r_div  <= w_load_dvs;
        r_dz   <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      r_cnt  <= r_cnt + 1'b1;
      r_high <= w_last ? w_r_fin : w_step_high;
      r_low  <= w_last ? w_q_fin : w_step_low;
    end
  end

endmodule

// File: doc/seq_shift_divide.md
Name: seq_shift_divide

Overview:
- Iterative restoring shift-subtract divider for the KGP-RISC ALU; the inverse of the shift-add multiply datapath.
- Uses the same high/low register-pair convention: remainder accumulates in high, quotient shifts into low.
- Resolves one quotient bit per clock and presents the result through a start/busy/done handshake to the ALU control.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- start_i  input  1  request a division; sampled only in IDLE or DONE.
- dividend_i  input  WIDTH  dividend, captured when start is accepted.
- divisor_i  input  WIDTH  divisor, captured when start is accepted.
- busy_o  output  1  high while a division is in progress.
- done_o  output  1  single-cycle pulse when the result becomes valid.
- div_zero_o  output  1  divisor was zero for the current result; held with the result.
- high_o  output  WIDTH  remainder.
- low_o  output  WIDTH  quotient.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - state=IDLE, counter=0.
  - busy_o=0, done_o=0, div_zero_o=0, high_o=0, low_o=0.
  - Reset wins over every other event, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start_i=1 and divisor_i!=0:
  - high=0, low=dividend_i, divisor register=divisor_i, counter=0.
  - div_zero_o=0, state goes to RUN.
- IDLE/DONE with start_i=1 and divisor_i==0:
  - high=dividend_i, low=all ones, div_zero_o=1.
  - Go to DONE next cycle; done_o pulses in the cycle after the start edge.
- RUN, once per cycle:
  - Form {high,low} shifted left by 1.
  - trial = shifted_high minus divisor, computed WIDTH+1 bits wide.
  - If trial is non-negative (MSB=0): high=trial[WIDTH-1:0] and low[0]=1.
  - Otherwise high=shifted_high and low[0]=0.
  - counter increments; after iteration WIDTH (counter==WIDTH-1 at that edge) go to DONE.
- Latency: start accepted at edge 0; iterations occupy edges 1..WIDTH; done_o=1 during the cycle after edge WIDTH (33 cycles for WIDTH=32).
- busy_o=1 exactly while state=RUN.
- done_o=1 only in the first cycle of DONE.
- high_o/low_o/div_zero_o hold their value in DONE until the next accepted start or reset.
- start_i while in RUN is ignored; no queuing.
- start_i in the DONE pulse cycle is accepted (back-to-back operation).
- Intermediate high_o/low_o values during RUN are don't-care to consumers.

Optional Feature:
- Macro: SEQ_SHIFT_DIVIDE_SIGNED_EN.
- Defined:
  - Operands are two's-complement.
  - At start, absolute values are loaded and the operand signs are registered.
  - On entering DONE, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
  - Divide-by-zero result is quotient=all ones (-1), remainder=dividend.
  - Most-negative / -1 returns quotient=0x80000000, remainder 0.
  - Latency unchanged.
- Undefined: purely unsigned; no sign registers are synthesised.

Decomposition:
- Shared package alu_pkg:
  - WIDTH default constant.
  - State typedef (IDLE/RUN/DONE).
  - Divide-by-zero quotient constant (all ones).
- One natural sub-module: shift_divide_step.
  - Combinational single iteration: takes high/low/divisor, returns next high/low.
  - Instantiated once inside the RUN datapath.
  - Unit-testable on its own, mirroring the multiply step.

Test Plan:
- 100 / 7 -> done_o pulses exactly 33 cycles after the start edge; low_o=14, high_o=2, div_zero_o=0; busy_o high for 32 cycles.
- 0xFFFFFFFF / 1 -> low_o=0xFFFFFFFF, high_o=0; then 0x00000005 / 0x00000009 -> low_o=0, high_o=5.
- 0x1234 / 0 -> done_o the cycle after start; low_o=0xFFFFFFFF, high_o=0x1234, div_zero_o=1, busy_o never asserted.
- Start 100/7, re-pulse start_i with 50/5 at cycle 10 -> ignored; result still 14 r 2. Then start 50/5 in the done cycle -> 10 r 0 after another 33 cycles.
- Start 1000/3, drop rst_n_i at cycle 15 -> next cycle all outputs 0, state IDLE. A fresh 9/3 then yields 3 r 0.
- With SEQ_SHIFT_DIVIDE_SIGNED_EN:
  - -7 / 2 -> low_o=0xFFFFFFFD, high_o=0xFFFFFFFF.
  - 7 / -2 -> low_o=0xFFFFFFFD, high_o=1.
  - 0x80000000 / 0xFFFFFFFF -> low_o=0x80000000, high_o=0.
